// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers.
// Mode selectors and a constant-evaluable clog2.
package fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_adv_if.sv
// Request/status bundle between a FIFO user and sync_fifo_adv.
// The master drives requests, the slave (the FIFO) returns data and flags.
interface sync_fifo_adv_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);

   logic                  flush;
   logic                  wq;
   logic                  rq;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wq, rq, clr_err, wr_data,
      input  rd_data, rd_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  flush, wq, rq, clr_err, wr_data,
      output rd_data, rd_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one read port.
// REG_READ selects a registered (block) or combinational (distributed) read.
module sync_fifo_ram import fifo_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter bit REG_READ   = 1'b1,
   parameter int AW         = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   if (REG_READ) begin : g_blk
      (* ram_style = "block" *)
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
         rdata_d = rdata_q;
         if (re) rdata_d = mem[raddr];
      end

      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
         rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
   end else begin : g_dist
      (* ram_style = "distributed" *)
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic                  unused_re;

      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end

      // Read is continuous here, so the enable has no role.
      assign unused_re = re;
      assign rdata     = mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_adv.sv
// Synchronous FIFO with FWFT option, threshold flags and sticky errors.
// Validity is defined only by pointers/count; storage is never cleared.
module sync_fifo_adv import fifo_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int FWFT       = FWFT_OFF,
   parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 2,
   parameter int AEMPTY_TH  = 2
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_adv_if.slave bus
);

   localparam int DATA_DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW         = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
   localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DATA_DEPTH)) begin : g_bad_th
      $error("sync_fifo_adv: need AEMPTY_TH < AFULL_TH <= DATA_DEPTH");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  seen_q, seen_d;
   logic                  full, empty, wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   always_comb begin
      wr_acc     = bus.wq && !full && !bus.flush;
      rd_acc     = bus.rq && !empty && !bus.flush;
      wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      rd_valid_d = rd_acc;
      seen_d     = seen_q | rd_acc;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      // A fresh error in the same cycle beats clr_err.
      ovf_d = bus.clr_err ? 1'b0 : ovf_q;
      udf_d = bus.clr_err ? 1'b0 : udf_q;
      if (bus.wq && full && !bus.flush)  ovf_d = 1'b1;
      if (bus.rq && empty && !bus.flush) udf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         seen_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         seen_q     <= seen_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DATA_DEPTH),
      .REG_READ   (FWFT == FWFT_OFF)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.wr_data),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // The RAM read register has no reset, so mask it until a real read.
   if (FWFT == FWFT_OFF) begin : g_std
      assign bus.rd_data  = seen_q ? ram_rdata : '0;
      assign bus.rd_valid = rd_valid_q;
   end else begin : g_fwft
      logic unused_regs;
      assign unused_regs  = rd_valid_q ^ seen_q;
      assign bus.rd_data  = empty ? '0 : ram_rdata;
      assign bus.rd_valid = !empty;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_adv.sv
// Bench for sync_fifo_adv: both read modes side by side on shared stimulus,
// each cycle compared against a queue-based reference model.
module tb_sync_fifo_adv;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int AET   = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sync_fifo_adv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
   sync_fifo_adv_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

   assign b1.flush   = b0.flush;
   assign b1.wq      = b0.wq;
   assign b1.rq      = b0.rq;
   assign b1.clr_err = b0.clr_err;
   assign b1.wr_data = b0.wr_data;

   sync_fifo_adv #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (0),
      .AFULL_TH (AFT), .AEMPTY_TH (AET)
   ) u_std (.clk(clk), .rst(rst), .bus(b0.slave));

   sync_fifo_adv #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (1),
      .AFULL_TH (AFT), .AEMPTY_TH (AET)
   ) u_fwft (.clk(clk), .rst(rst), .bus(b1.slave));

   int errs   = 0;
   int checks = 0;

   logic [7:0] q[$];
   bit         m_ovf, m_udf, m_rv0;
   logic [7:0] m_rd0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_rv0 = 0;
      m_rd0 = 8'h00;
   endfunction

   function automatic void model_step();
      bit f, e;
      if (rst) begin
         model_reset();
         return;
      end
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      m_rv0 = 0;
      if (b0.flush) begin
         q.delete();
      end else begin
         if (b0.rq && !e) begin
            m_rd0 = q.pop_front();
            m_rv0 = 1;
         end
         if (b0.wq && !f) q.push_back(b0.wr_data);
      end
      if (b0.clr_err) begin
         m_ovf = 0;
         m_udf = 0;
      end
      if (!b0.flush && b0.wq && f) m_ovf = 1;
      if (!b0.flush && b0.rq && e) m_udf = 1;
   endfunction

   task automatic check_all();
      int n;
      logic [7:0] head;
      n    = q.size();
      head = (n > 0) ? q[0] : 8'h00;
      chk("std.count", 32'(b0.count), n);
      chk("std.full", 32'(b0.full), 32'(n == DEPTH));
      chk("std.empty", 32'(b0.empty), 32'(n == 0));
      chk("std.afull", 32'(b0.almost_full), 32'(n >= AFT));
      chk("std.aempty", 32'(b0.almost_empty), 32'(n <= AET));
      chk("std.ovf", 32'(b0.overflow), 32'(m_ovf));
      chk("std.udf", 32'(b0.underflow), 32'(m_udf));
      chk("std.rd_data", 32'(b0.rd_data), 32'(m_rd0));
      chk("std.rd_valid", 32'(b0.rd_valid), 32'(m_rv0));
      chk("fwft.count", 32'(b1.count), n);
      chk("fwft.full", 32'(b1.full), 32'(n == DEPTH));
      chk("fwft.empty", 32'(b1.empty), 32'(n == 0));
      chk("fwft.afull", 32'(b1.almost_full), 32'(n >= AFT));
      chk("fwft.aempty", 32'(b1.almost_empty), 32'(n <= AET));
      chk("fwft.ovf", 32'(b1.overflow), 32'(m_ovf));
      chk("fwft.udf", 32'(b1.underflow), 32'(m_udf));
      chk("fwft.rd_data", 32'(b1.rd_data), 32'(head));
      chk("fwft.rd_valid", 32'(b1.rd_valid), 32'(n != 0));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input bit w, input bit r, input logic [7:0] d,
                        input bit f = 0, input bit c = 0);
      b0.wq      = w;
      b0.rq      = r;
      b0.wr_data = d;
      b0.flush   = f;
      b0.clr_err = c;
   endtask

   // Async reset raised between edges; outputs must drop before any edge.
   task automatic rst_mid();
      @(posedge clk);
      model_step();
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("rst.count", 32'(b0.count), 0);
      chk("rst.std_rd", 32'(b0.rd_data), 0);
      cyc();
      rst = 1'b0;
   endtask

   logic [7:0] fill [4];
   int         pct;

   initial begin
      fill = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst  = 1'b1;
      drive(0, 0, 8'h00);
      model_reset();
      repeat (2) cyc();
      rst = 1'b0;
      cyc();

      // Fill to full, then overflow.
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, fill[i]);
         cyc();
         if (i == 2) chk("fill.af3", 32'(b0.almost_full), 1);
      end
      chk("fill.full", 32'(b0.full), 1);
      chk("fill.cnt", 32'(b0.count), 4);
      drive(1, 0, 8'h55);
      cyc();
      chk("ovf.set", 32'(b0.overflow), 1);
      chk("ovf.cnt", 32'(b0.count), 4);

      // Set beats clear, then clear alone.
      drive(1, 0, 8'h66, 0, 1);
      cyc();
      chk("ovf.win", 32'(b0.overflow), 1);
      drive(0, 0, 8'h00, 0, 1);
      cyc();
      chk("ovf.clr", 32'(b0.overflow), 0);

      // Drain in order, then underflow.
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 8'h00);
         cyc();
         chk("drain.data", 32'(b0.rd_data), 32'(fill[i]));
         chk("drain.vld", 32'(b0.rd_valid), 1);
      end
      drive(0, 0, 8'h00);
      cyc();
      chk("drain.hold", 32'(b0.rd_data), 32'h44);
      chk("drain.vld0", 32'(b0.rd_valid), 0);
      drive(0, 1, 8'h00);
      cyc();
      chk("udf.set", 32'(b0.underflow), 1);
      drive(0, 0, 8'h00, 0, 1);
      cyc();

      // Fall-through of a single word.
      drive(1, 0, 8'hA5);
      cyc();
      chk("fwft.a5", 32'(b1.rd_data), 32'hA5);
      chk("fwft.a5v", 32'(b1.rd_valid), 1);
      drive(0, 1, 8'h00);
      cyc();
      chk("fwft.pop", 32'(b1.empty), 1);

      // Steady state at count 2 across pointer wrap.
      drive(1, 0, 8'd1);
      cyc();
      drive(1, 0, 8'd2);
      cyc();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 8'(i + 3));
         cyc();
         chk("wrap.cnt", 32'(b0.count), 2);
         chk("wrap.data", 32'(b0.rd_data), 32'(i + 1));
      end

      // Flush with a concurrent write.
      drive(1, 0, 8'h70);
      cyc();
      chk("pre_flush.cnt", 32'(b0.count), 3);
      drive(1, 0, 8'h77, 1);
      cyc();
      chk("flush.cnt", 32'(b0.count), 0);
      chk("flush.empty", 32'(b1.empty), 1);

      // Reset in the middle of a write burst.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 8'(8'h80 + i));
         cyc();
      end
      rst_mid();
      drive(1, 0, 8'h99);
      cyc();
      chk("post_rst.fwft", 32'(b1.rd_data), 32'h99);
      chk("post_rst.cnt", 32'(b0.count), 1);

      // Random traffic with drifting fill bias.
      for (int i = 0; i < 600; i++) begin
         pct = ((i / 50) % 2 == 0) ? 75 : 25;
         drive($urandom_range(0, 99) < pct,
               $urandom_range(0, 99) < (100 - pct),
               8'($urandom),
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 15) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
